ibex_ibus_arbiter: RTL and testbench

IBEX_IBUS_ARBITER -- requirements
Module: ibex_ibus_arbiter

---
 rtl/ibex_pkg.sv | 10 +
 rtl/ibex_ibus_arbiter.sv | 138 +++++++++++++
 tb/tb_ibex_ibus_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the instruction-bus arbiter.
// Requester IDs double as ID-queue entries.
package ibex_pkg;

  typedef enum logic {
    IBUS_SRC_PF  = 1'b0,
    IBUS_SRC_AUX = 1'b1
  } ibus_src_e;

endpackage

// File: rtl/ibex_ibus_arbiter.sv
// Two-requester instruction-bus arbiter with
// grant locking and an in-order response ID queue.
module ibex_ibus_arbiter
  import ibex_pkg::*;
#(
  parameter int MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pf_req_i,
  input  logic [31:0] pf_addr_i,
  output logic        pf_gnt_o,
  output logic        pf_rvalid_o,
  input  logic        aux_req_i,
  input  logic [31:0] aux_addr_i,
  output logic        aux_gnt_o,
  output logic        aux_rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        instr_rvalid_i,
  output logic        busy_o
);

  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam int PW = (MaxOutstanding > 1) ?
                      $clog2(MaxOutstanding) : 1;

  logic [CW-1:0] count_q;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  ibus_src_e     ids_q [MaxOutstanding];
  logic          lock_q;
  ibus_src_e     owner_q;
  ibus_src_e     last_q;

  logic          sel_valid;
  ibus_src_e     sel;
  logic          can_req;
  logic          gnt;
  logic          push;
  logic          pop;
  logic [31:0]   sel_addr;

  // Pick the owner: a locked owner wins, else round-robin.
  always_comb begin
    sel_valid = 1'b0;
    sel       = IBUS_SRC_PF;
    unique case (1'b1)
      lock_q: begin
        sel_valid = 1'b1;
        sel       = owner_q;
      end
      !lock_q && pf_req_i && aux_req_i: begin
        sel_valid = 1'b1;
        sel       = (last_q == IBUS_SRC_PF) ?
                    IBUS_SRC_AUX : IBUS_SRC_PF;
      end
      !lock_q && pf_req_i && !aux_req_i: begin
        sel_valid = 1'b1;
        sel       = IBUS_SRC_PF;
      end
      !lock_q && !pf_req_i && aux_req_i: begin
        sel_valid = 1'b1;
        sel       = IBUS_SRC_AUX;
      end
      default: ;
    endcase
  end

  assign can_req  = count_q < CW'(MaxOutstanding);
  assign sel_addr = (sel == IBUS_SRC_PF) ?
                    pf_addr_i : aux_addr_i;

  assign instr_req_o  = rst_ni & sel_valid & can_req;
  assign instr_addr_o = {sel_addr[31:2], 2'b00};
  assign gnt          = instr_req_o & instr_gnt_i;
  assign pf_gnt_o     = gnt & (sel == IBUS_SRC_PF);
  assign aux_gnt_o    = gnt & (sel == IBUS_SRC_AUX);

  assign push = gnt;
  assign pop  = rst_ni & instr_rvalid_i &
                (count_q != '0);

  assign pf_rvalid_o  = pop &
                        (ids_q[rptr_q] == IBUS_SRC_PF);
  assign aux_rvalid_o = pop &
                        (ids_q[rptr_q] == IBUS_SRC_AUX);
  assign rdata_o      = instr_rdata_i;
  assign err_o        = instr_err_i;
  assign busy_o       = (count_q != '0) | instr_req_o;

  // Hold the owner across stalled requests; track last grant.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q  <= 1'b0;
      owner_q <= IBUS_SRC_PF;
      last_q  <= IBUS_SRC_AUX;
    end else if (gnt) begin
      lock_q  <= 1'b0;
      last_q  <= sel;
    end else if (instr_req_o) begin
      lock_q  <= 1'b1;
      owner_q <= sel;
    end
  end

  // In-order ID queue: push on grant, pop on response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      count_q <= count_q + CW'(push) - CW'(pop);
      if (push) begin
        ids_q[wptr_q] <= sel;
        wptr_q <= (wptr_q == PW'(MaxOutstanding - 1)) ?
                  '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == PW'(MaxOutstanding - 1)) ?
                  '0 : rptr_q + 1'b1;
      end
    end
  end

  // Responses with nothing outstanding are dropped and flagged.
  stray_rvalid_a : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(instr_rvalid_i && (count_q == '0))
  ) else $warning("stray instr_rvalid_i ignored");

endmodule

// File: tb/tb_ibex_ibus_arbiter.sv
// Directed bench for ibex_ibus_arbiter.
// Vector table plus reset-with-outstanding sequence.
module tb_ibex_ibus_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        pf_req, aux_req;
  logic [31:0] pf_addr, aux_addr;
  logic        pf_gnt, pf_rvalid;
  logic        aux_gnt, aux_rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        instr_req, instr_gnt;
  logic [31:0] instr_addr, instr_rdata;
  logic        instr_err, instr_rvalid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ibex_ibus_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .pf_req_i       (pf_req),
    .pf_addr_i      (pf_addr),
    .pf_gnt_o       (pf_gnt),
    .pf_rvalid_o    (pf_rvalid),
    .aux_req_i      (aux_req),
    .aux_addr_i     (aux_addr),
    .aux_gnt_o      (aux_gnt),
    .aux_rvalid_o   (aux_rvalid),
    .rdata_o        (rdata),
    .err_o          (err),
    .instr_req_o    (instr_req),
    .instr_gnt_i    (instr_gnt),
    .instr_addr_o   (instr_addr),
    .instr_rdata_i  (instr_rdata),
    .instr_err_i    (instr_err),
    .instr_rvalid_i (instr_rvalid),
    .busy_o         (busy)
  );

  typedef struct {
    logic        pf;
    logic        aux;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        er;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_pgnt;
    logic        e_agnt;
    logic        e_prv;
    logic        e_arv;
    logic        e_busy;
  } vec_t;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic a,
                       input logic g, input logic r);
    pf_req       = p;
    aux_req      = a;
    instr_gnt    = g;
    instr_rvalid = r;
  endtask

  vec_t v [15];

  initial begin
    rst_ni      = 1'b0;
    pf_addr     = 32'h0000_0100;
    aux_addr    = 32'h0000_0203;
    instr_rdata = '0;
    instr_err   = 1'b0;
    drive(0, 0, 0, 0);

    // pf aux gnt rv rdata err | req addr pg ag prv arv busy
    v[0]  = '{0,0,0,0,32'h0,0,          0,32'h100,0,0,0,0,0};
    v[1]  = '{1,1,0,0,32'h0,0,          1,32'h100,0,0,0,0,1};
    v[2]  = '{1,1,0,0,32'h0,0,          1,32'h100,0,0,0,0,1};
    v[3]  = '{1,1,0,0,32'h0,0,          1,32'h100,0,0,0,0,1};
    v[4]  = '{1,1,1,0,32'h0,0,          1,32'h100,1,0,0,0,1};
    v[5]  = '{1,1,1,0,32'h0,0,          1,32'h200,0,1,0,0,1};
    v[6]  = '{1,1,1,0,32'h0,0,          0,32'h100,0,0,0,0,1};
    v[7]  = '{1,1,1,1,32'hDEADBEEF,0,   0,32'h100,0,0,1,0,1};
    v[8]  = '{1,1,1,1,32'h1234_5678,1,  1,32'h100,1,0,0,1,1};
    v[9]  = '{1,1,0,1,32'hCAFE_F00D,0,  1,32'h200,0,0,1,0,1};
    v[10] = '{1,1,0,0,32'h0,0,          1,32'h200,0,0,0,0,1};
    v[11] = '{1,1,1,0,32'h0,0,          1,32'h200,0,1,0,0,1};
    v[12] = '{0,0,0,1,32'hA5A5_5A5A,0,  0,32'h100,0,0,0,1,1};
    v[13] = '{0,0,0,1,32'h0,0,          0,32'h100,0,0,0,0,0};
    v[14] = '{0,0,0,0,32'h0,0,          0,32'h100,0,0,0,0,0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", instr_req, 0);
    chk("rst_pgnt", pf_gnt, 0);
    chk("rst_agnt", aux_gnt, 0);
    chk("rst_prv", pf_rvalid, 0);
    chk("rst_arv", aux_rvalid, 0);
    chk("rst_busy", busy, 0);
    rst_ni = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(v[i].pf, v[i].aux, v[i].gnt, v[i].rv);
      instr_rdata = v[i].rd;
      instr_err   = v[i].er;
      #1;
      chk($sformatf("v%0d_req", i), instr_req, v[i].e_req);
      if (v[i].e_req)
        chk($sformatf("v%0d_addr", i),
            instr_addr, v[i].e_addr);
      chk($sformatf("v%0d_pgnt", i), pf_gnt, v[i].e_pgnt);
      chk($sformatf("v%0d_agnt", i), aux_gnt, v[i].e_agnt);
      chk($sformatf("v%0d_prv", i), pf_rvalid, v[i].e_prv);
      chk($sformatf("v%0d_arv", i), aux_rvalid, v[i].e_arv);
      chk($sformatf("v%0d_busy", i), busy, v[i].e_busy);
      chk($sformatf("v%0d_rdata", i), rdata, v[i].rd);
      chk($sformatf("v%0d_err", i), err, v[i].er);
    end

    // Two outstanding, then reset discards them.
    @(negedge clk);
    drive(1, 0, 1, 0);
    #1;
    chk("r_pgnt", pf_gnt, 1);
    @(negedge clk);
    drive(0, 1, 1, 0);
    #1;
    chk("r_agnt", aux_gnt, 1);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("r_busy_pre", busy, 1);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("r_busy_post", busy, 0);
    chk("r_req_post", instr_req, 0);
    @(negedge clk);
    drive(0, 0, 0, 1);
    #1;
    chk("r_stray_prv", pf_rvalid, 0);
    chk("r_stray_arv", aux_rvalid, 0);
    chk("r_stray_busy", busy, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("r_final_busy", busy, 0);
    // Fresh state after reset: pf wins a tie.
    @(negedge clk);
    drive(1, 1, 1, 0);
    #1;
    chk("r_tie_pgnt", pf_gnt, 1);
    chk("r_tie_agnt", aux_gnt, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
